// File: rtl/ps2_key_capture_pkg.sv
// Shared types, codes and lookup tables for the PS/2 key capture block.
package ps2_key_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Scan code set 2 make codes for letters and top-row digits; 0x00 means unmapped.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] result;
    case (code)
      8'h1C: result = 8'h41;  8'h32: result = 8'h42;  8'h21: result = 8'h43;
      8'h23: result = 8'h44;  8'h24: result = 8'h45;  8'h2B: result = 8'h46;
      8'h34: result = 8'h47;  8'h33: result = 8'h48;  8'h43: result = 8'h49;
      8'h3B: result = 8'h4A;  8'h42: result = 8'h4B;  8'h4B: result = 8'h4C;
      8'h3A: result = 8'h4D;  8'h31: result = 8'h4E;  8'h44: result = 8'h4F;
      8'h4D: result = 8'h50;  8'h15: result = 8'h51;  8'h2D: result = 8'h52;
      8'h1B: result = 8'h53;  8'h2C: result = 8'h54;  8'h3C: result = 8'h55;
      8'h2A: result = 8'h56;  8'h1D: result = 8'h57;  8'h22: result = 8'h58;
      8'h35: result = 8'h59;  8'h1A: result = 8'h5A;
      8'h45: result = 8'h30;  8'h16: result = 8'h31;  8'h1E: result = 8'h32;
      8'h26: result = 8'h33;  8'h25: result = 8'h34;  8'h2E: result = 8'h35;
      8'h36: result = 8'h36;  8'h3D: result = 8'h37;  8'h3E: result = 8'h38;
      8'h46: result = 8'h39;
      default: result = 8'h00;
    endcase
    return result;
  endfunction

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ps2_key_capture_seg7.sv
// One hexadecimal digit to active-low seven-segment pattern.
module hex_seg7_decoder
  import ps2_key_capture_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/ps2_key_capture.sv
// PS/2 frame receiver clocked by the keyboard clock, with make-code to ASCII
// translation, a short ASCII history and a two-digit hex display of the last character.
module ps2_key_capture
  import ps2_key_capture_pkg::*;
#(
  parameter int HISTORY_CHARS = 4
) (
  input  logic                       ps2_clock,
  input  logic                       reset,
  input  logic                       ps2_data,
  output logic [7:0]                 scan_code,
  output logic [7:0]                 ascii,
  output logic                       key_valid,
  output logic                       parity_error,
  output logic [8*HISTORY_CHARS-1:0] history,
  output logic [6:0]                 seg_lo,
  output logic [6:0]                 seg_hi
);

  localparam int HIST_W = 8 * HISTORY_CHARS;

  state_t            state;
  logic [7:0]        shift;
  logic [2:0]        bit_count;
  logic              parity_bit;
  logic              break_pending;
  logic              ext_pending;
  logic              frame_good;
  logic [7:0]        mapped;
  logic [HIST_W-1:0] mapped_wide;

  // Evaluated during STOP: ps2_data is the stop bit, shift/parity_bit hold the frame.
  assign frame_good  = ps2_data && (^{shift, parity_bit});
  assign mapped      = scan_to_ascii(shift);
  assign mapped_wide = HIST_W'(mapped);

  always_ff @(negedge ps2_clock) begin
    if (reset) begin
      state         <= IDLE;
      shift         <= 8'h00;
      bit_count     <= 3'd0;
      parity_bit    <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      scan_code     <= 8'h00;
      ascii         <= 8'h00;
      key_valid     <= 1'b0;
      parity_error  <= 1'b0;
      history       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ps2_data) begin
            state     <= DATA;
            bit_count <= 3'd0;
            key_valid <= 1'b0;
          end
        end
        DATA: begin
          shift     <= {ps2_data, shift[7:1]};
          bit_count <= bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            state <= PARITY;
          end
        end
        PARITY: begin
          parity_bit <= ps2_data;
          state      <= STOP;
        end
        STOP: begin
          state <= IDLE;
          if (!frame_good) begin
            parity_error <= 1'b1;
            key_valid    <= 1'b0;
          end else begin
            parity_error <= 1'b0;
            scan_code    <= shift;
            key_valid    <= 1'b0;
            if (shift == BREAK_CODE) begin
              break_pending <= 1'b1;
            end else if (shift == EXT_CODE) begin
              ext_pending <= 1'b1;
            end else if (break_pending) begin
              // Release of a key: swallow it so ascii keeps the last press.
              break_pending <= 1'b0;
              ext_pending   <= 1'b0;
            end else begin
              ascii       <= mapped;
              ext_pending <= 1'b0;
              if (mapped != 8'h00) begin
                key_valid <= 1'b1;
                history   <= (history << 8) | mapped_wide;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  hex_seg7_decoder u_seg_lo (
    .nibble (ascii[3:0]),
    .seg    (seg_lo)
  );

  hex_seg7_decoder u_seg_hi (
    .nibble (ascii[7:4]),
    .seg    (seg_hi)
  );

endmodule

// File: tb/tb_ps2_key_capture.sv
// Directed bench: PS/2 frames bit-banged on the data line against a free-running keyboard clock.
module tb_ps2_key_capture;

  logic        ps2_clock;
  logic        reset;
  logic        ps2_data;
  logic [7:0]  scan_code;
  logic [7:0]  ascii;
  logic        key_valid;
  logic        parity_error;
  logic [31:0] history;
  logic [6:0]  seg_lo;
  logic [6:0]  seg_hi;

  int checks = 0;
  int errors = 0;

  ps2_key_capture #(.HISTORY_CHARS(4)) dut (
    .ps2_clock    (ps2_clock),
    .reset        (reset),
    .ps2_data     (ps2_data),
    .scan_code    (scan_code),
    .ascii        (ascii),
    .key_valid    (key_valid),
    .parity_error (parity_error),
    .history      (history),
    .seg_lo       (seg_lo),
    .seg_hi       (seg_hi)
  );

  initial ps2_clock = 1'b1;
  always #10 ps2_clock = ~ps2_clock;

  // Frame bits in wire order: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic par, input logic stp);
    return {stp, par, data, 1'b0};
  endfunction

  // Data changes on the rising edge; results are sampled just after the falling edge.
  task automatic drive_bits(input logic [10:0] frame, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge ps2_clock);
      ps2_data = frame[i];
    end
    @(negedge ps2_clock);
    #2;
    if (last == 10) begin
      ps2_data = 1'b1;
      $display("frame data=%02h par=%0b stop=%0b -> scan=%02h ascii=%02h kv=%0b perr=%0b hist=%08h seg=%02h/%02h",
               frame[8:1], frame[9], frame[10], scan_code, ascii, key_valid, parity_error, history, seg_hi, seg_lo);
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge ps2_clock);
    #2;
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan got %02h want 00", scan_code); end
    checks++; if (ascii !== 8'h00) begin errors++; $display("FAIL reset_ascii got %02h want 00", ascii); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %0b want 0", key_valid); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr got %0b want 0", parity_error); end
    checks++; if (history !== 32'h0) begin errors++; $display("FAIL reset_hist got %08h want 00000000", history); end
    checks++; if (seg_lo !== 7'h40 || seg_hi !== 7'h40) begin errors++; $display("FAIL reset_seg got %02h/%02h want 40/40", seg_hi, seg_lo); end
    reset = 1'b0;
  endtask

  task automatic test_make_codes;
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL make_a_scan got %02h want 1C", scan_code); end
    checks++; if (ascii !== 8'h41) begin errors++; $display("FAIL make_a_ascii got %02h want 41", ascii); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL make_a_kv got %0b want 1", key_valid); end
    checks++; if (history !== 32'h00000041) begin errors++; $display("FAIL make_a_hist got %08h want 00000041", history); end
    checks++; if (seg_lo !== 7'h79 || seg_hi !== 7'h19) begin errors++; $display("FAIL make_a_seg got %02h/%02h want 19/79", seg_hi, seg_lo); end
    drive_bits(make_frame(8'h32, 1'b0, 1'b1), 0, 10);
    checks++; if (ascii !== 8'h42) begin errors++; $display("FAIL make_b_ascii got %02h want 42", ascii); end
    drive_bits(make_frame(8'h16, 1'b0, 1'b1), 0, 10);
    checks++; if (history !== 32'h00414231) begin errors++; $display("FAIL make_1_hist got %08h want 00414231", history); end
    checks++; if (ascii !== 8'h31) begin errors++; $display("FAIL make_1_ascii got %02h want 31", ascii); end
    checks++; if (seg_lo !== 7'h79 || seg_hi !== 7'h30) begin errors++; $display("FAIL make_1_seg got %02h/%02h want 30/79", seg_hi, seg_lo); end
  endtask

  task automatic test_valid_clears_on_start;
    drive_bits(make_frame(8'h45, 1'b0, 1'b1), 0, 0);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL start_kv got %0b want 0", key_valid); end
    checks++; if (ascii !== 8'h31) begin errors++; $display("FAIL start_ascii got %02h want 31", ascii); end
    drive_bits(make_frame(8'h45, 1'b0, 1'b1), 1, 10);
    checks++; if (ascii !== 8'h30 || key_valid !== 1'b1) begin errors++; $display("FAIL digit0 got ascii=%02h kv=%0b want 30/1", ascii, key_valid); end
    checks++; if (history !== 32'h41423130) begin errors++; $display("FAIL digit0_hist got %08h want 41423130", history); end
    checks++; if (seg_lo !== 7'h40 || seg_hi !== 7'h30) begin errors++; $display("FAIL digit0_seg got %02h/%02h want 30/40", seg_hi, seg_lo); end
  endtask

  task automatic test_break;
    drive_bits(make_frame(8'hF0, 1'b1, 1'b1), 0, 10);
    checks++; if (scan_code !== 8'hF0 || key_valid !== 1'b0) begin errors++; $display("FAIL brk_f0 got scan=%02h kv=%0b want F0/0", scan_code, key_valid); end
    checks++; if (ascii !== 8'h30) begin errors++; $display("FAIL brk_f0_ascii got %02h want 30", ascii); end
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++; if (scan_code !== 8'h1C || key_valid !== 1'b0) begin errors++; $display("FAIL brk_rel got scan=%02h kv=%0b want 1C/0", scan_code, key_valid); end
    checks++; if (ascii !== 8'h30) begin errors++; $display("FAIL brk_rel_ascii got %02h want 30", ascii); end
    checks++; if (history !== 32'h41423130) begin errors++; $display("FAIL brk_rel_hist got %08h want 41423130", history); end
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++; if (ascii !== 8'h41 || key_valid !== 1'b1) begin errors++; $display("FAIL brk_cleared got ascii=%02h kv=%0b want 41/1", ascii, key_valid); end
    checks++; if (history !== 32'h42313041) begin errors++; $display("FAIL brk_cleared_hist got %08h want 42313041", history); end
  endtask

  task automatic test_extended;
    drive_bits(make_frame(8'hE0, 1'b0, 1'b1), 0, 10);
    checks++; if (scan_code !== 8'hE0 || key_valid !== 1'b0) begin errors++; $display("FAIL ext_e0 got scan=%02h kv=%0b want E0/0", scan_code, key_valid); end
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++; if (ascii !== 8'h41 || key_valid !== 1'b1) begin errors++; $display("FAIL ext_key got ascii=%02h kv=%0b want 41/1", ascii, key_valid); end
    checks++; if (history !== 32'h31304141) begin errors++; $display("FAIL ext_hist got %08h want 31304141", history); end
  endtask

  task automatic test_parity_error;
    drive_bits(make_frame(8'h32, 1'b1, 1'b1), 0, 10);
    checks++; if (parity_error !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL par_bad got perr=%0b kv=%0b want 1/0", parity_error, key_valid); end
    checks++; if (scan_code !== 8'h1C || ascii !== 8'h41) begin errors++; $display("FAIL par_hold got scan=%02h ascii=%02h want 1C/41", scan_code, ascii); end
    checks++; if (history !== 32'h31304141) begin errors++; $display("FAIL par_hist got %08h want 31304141", history); end
    drive_bits(make_frame(8'h32, 1'b0, 1'b0), 0, 10);
    checks++; if (parity_error !== 1'b1 || scan_code !== 8'h1C) begin errors++; $display("FAIL stop_bad got perr=%0b scan=%02h want 1/1C", parity_error, scan_code); end
    drive_bits(make_frame(8'h16, 1'b0, 1'b1), 0, 10);
    checks++; if (parity_error !== 1'b0 || key_valid !== 1'b1) begin errors++; $display("FAIL par_recover got perr=%0b kv=%0b want 0/1", parity_error, key_valid); end
    checks++; if (history !== 32'h30414131) begin errors++; $display("FAIL par_recover_hist got %08h want 30414131", history); end
  endtask

  task automatic test_unmapped;
    drive_bits(make_frame(8'h76, 1'b0, 1'b1), 0, 10);
    checks++; if (scan_code !== 8'h76 || ascii !== 8'h00) begin errors++; $display("FAIL unm got scan=%02h ascii=%02h want 76/00", scan_code, ascii); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL unm_kv got %0b want 0", key_valid); end
    checks++; if (seg_lo !== 7'h40 || seg_hi !== 7'h40) begin errors++; $display("FAIL unm_seg got %02h/%02h want 40/40", seg_hi, seg_lo); end
    checks++; if (history !== 32'h30414131) begin errors++; $display("FAIL unm_hist got %08h want 30414131", history); end
  endtask

  task automatic test_reset_mid_frame;
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 4);
    reset = 1'b1;
    repeat (2) @(negedge ps2_clock);
    #2;
    checks++; if (scan_code !== 8'h00 || ascii !== 8'h00 || history !== 32'h0) begin errors++; $display("FAIL mid_reset got scan=%02h ascii=%02h hist=%08h want 00/00/00000000", scan_code, ascii, history); end
    reset    = 1'b0;
    ps2_data = 1'b1;
    drive_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++; if (ascii !== 8'h41 || key_valid !== 1'b1 || parity_error !== 1'b0) begin errors++; $display("FAIL mid_after got ascii=%02h kv=%0b perr=%0b want 41/1/0", ascii, key_valid, parity_error); end
    checks++; if (history !== 32'h00000041) begin errors++; $display("FAIL mid_after_hist got %08h want 00000041", history); end
  endtask

  initial begin
    test_reset();
    test_make_codes();
    test_valid_clears_on_start();
    test_break();
    test_extended();
    test_parity_error();
    test_unmapped();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
